// File: rtl/turtle_dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// turtle_dmem_arbiter_if
//   Bus bundle between the two data-memory requesters (CPU core "c", debug /
//   program loader "d"), the arbiter, and the single-port data_memory.
//
//   Signal groups:
//     c_*   core request (req/we/addr/wdata), grant, registered read return
//     d_*   debug request (adds d_lock), grant, registered read return
//     mem_* memory drive (addr/write_data/write_enable/output_enable) and the
//           memory's read_data coming back
//
//   Modports:
//     master  the environment side: requesters plus the memory itself
//     slave   the arbiter
// -----------------------------------------------------------------------------
interface turtle_dmem_arbiter_if #(
  parameter int DATA_W   = 8,
  parameter int D_ADDR_W = 12
);

  // Core requester
  logic                c_req;
  logic                c_we;
  logic [D_ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0]   c_wdata;
  logic                c_gnt;
  logic                c_rvalid;
  logic [DATA_W-1:0]   c_rdata;

  // Debug / loader requester
  logic                d_req;
  logic                d_we;
  logic                d_lock;
  logic [D_ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  // Single-port data memory
  logic [D_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]   mem_write_data;
  logic                mem_write_enable;
  logic                mem_output_enable;
  logic [DATA_W-1:0]   mem_read_data;

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_lock, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_write_data, mem_write_enable, mem_output_enable,
    output mem_read_data
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_lock, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_write_data, mem_write_enable, mem_output_enable,
    input  mem_read_data
  );

endinterface : turtle_dmem_arbiter_if

// File: rtl/turtle_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// turtle_dmem_arbiter
//   Shares the single-port data memory between the CPU core (C) and the
//   debug / program-loader port (D).
//
//   - Fixed priority to C. A starvation counter forces a D grant once D has
//     been denied MAX_WAIT consecutive cycles.
//   - D may request lock mode (d_lock) to own the memory for back-to-back
//     bursts; while locked, C is never granted.
//   - Grants are combinational: an access completes in its request cycle.
//   - Read data is captured at the clock edge ending the granted read and
//     returned the next cycle with a one-cycle rvalid strobe per requester.
//
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    turtle_dmem_arbiter_if.slave (requesters + memory signals)
// -----------------------------------------------------------------------------
module turtle_dmem_arbiter #(
  parameter int DATA_W   = 8,
  parameter int D_ADDR_W = 12,
  parameter int MAX_WAIT = 4,   // 1 .. 2**WAIT_W-1
  parameter int WAIT_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  turtle_dmem_arbiter_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [0:0] ST_ARB  = 1'b0;  // normal priority arbitration
  localparam logic [0:0] ST_LOCK = 1'b1;  // D owns the memory

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic [0:0]        state_q,    state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              c_rvalid_q, c_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] c_rdata_q,  c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;

  logic              c_gnt;
  logic              d_gnt;
  logic              d_starved;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  assign d_starved = (wait_cnt_q == MAX_WAIT_C);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    // Grants are suppressed while reset is held, even though state is only
    // cleared at the edge, so memory is never touched during reset.
    if (!reset) begin
      case (state_q)
        ST_ARB: begin
          if (bus.d_req && (!bus.c_req || d_starved)) begin
            d_gnt = 1'b1;
          end else if (bus.c_req) begin
            c_gnt = 1'b1;
          end
        end
        ST_LOCK: begin
          d_gnt = bus.d_req;
        end
        default: begin
          c_gnt = 1'b0;
          d_gnt = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory drive: steered from whichever requester holds the grant; all zero
  // when idle so the memory bus is quiet between accesses.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mem_addr          = '0;
    bus.mem_write_data    = '0;
    bus.mem_write_enable  = 1'b0;
    bus.mem_output_enable = 1'b0;
    if (c_gnt) begin
      bus.mem_addr          = bus.c_addr;
      bus.mem_write_data    = bus.c_wdata;
      bus.mem_write_enable  = bus.c_we;
      bus.mem_output_enable = !bus.c_we;
    end else if (d_gnt) begin
      bus.mem_addr          = bus.d_addr;
      bus.mem_write_data    = bus.d_wdata;
      bus.mem_write_enable  = bus.d_we;
      bus.mem_output_enable = !bus.d_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: lock ownership and starvation counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_ARB: begin
        if (d_gnt && bus.d_lock) begin
          state_d = ST_LOCK;
        end
        if (d_gnt || !bus.d_req) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_LOCK: begin
        // In LOCK a pending d_req is always granted, so leaving on !d_lock
        // covers "granted without lock"; the counter stays frozen here.
        if (!bus.d_req || !bus.d_lock) begin
          state_d = ST_ARB;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read return: capture memory data at the end of a granted read. rdata holds
  // until the same requester's next read.
  // ---------------------------------------------------------------------------
  always_comb begin
    c_rvalid_d = c_gnt && !bus.c_we;
    d_rvalid_d = d_gnt && !bus.d_we;
    c_rdata_d  = c_rvalid_d ? bus.mem_read_data : c_rdata_q;
    d_rdata_d  = d_rvalid_d ? bus.mem_read_data : d_rdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ARB;
      wait_cnt_q <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.c_gnt    = c_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.c_rvalid = c_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.c_rdata  = c_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule : turtle_dmem_arbiter

// File: tb/tb_turtle_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_turtle_dmem_arbiter
//   Randomized bench for turtle_dmem_arbiter. A behavioural model tracks who
//   owns the memory (locked flag), how long D has been kept waiting, and a
//   shadow copy of memory contents; each cycle the DUT's grants, memory drive
//   and read return are compared against it. A few directed sequences cover
//   the reset, core-read and starvation scenarios with fixed expectations.
// -----------------------------------------------------------------------------
module tb_turtle_dmem_arbiter;

  localparam int DATA_W   = 8;
  localparam int D_ADDR_W = 12;
  localparam int MAX_WAIT = 4;
  localparam int WAIT_W   = 3;
  localparam int MEM_SZ   = 1 << D_ADDR_W;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  turtle_dmem_arbiter_if #(.DATA_W(DATA_W), .D_ADDR_W(D_ADDR_W)) bus ();

  turtle_dmem_arbiter #(
    .DATA_W  (DATA_W),
    .D_ADDR_W(D_ADDR_W),
    .MAX_WAIT(MAX_WAIT),
    .WAIT_W  (WAIT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Environment memory (what the DUT actually reads/writes) and the model's
  // independent shadow of what memory should contain.
  logic [DATA_W-1:0] env_mem [MEM_SZ];
  logic [DATA_W-1:0] shadow  [MEM_SZ];

  assign bus.mem_read_data = env_mem[bus.mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit                m_locked;
  int                m_denied;
  bit                m_c_rv, m_d_rv;
  logic [DATA_W-1:0] m_c_rdata, m_d_rdata;
  bit                last_c, last_d;   // model grants of the previous cycle

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  // One clock cycle: compare at the negedge, apply memory write and advance
  // the model just after the posedge.
  task automatic run_cycle();
    bit                  ec, ed, c_rd, d_rd;
    logic [D_ADDR_W-1:0] ea;
    logic [DATA_W-1:0]   ew;
    bit                  ewe, eoe;
    bit                  w_en;
    logic [D_ADDR_W-1:0] w_a;
    logic [DATA_W-1:0]   w_d;

    @(negedge clk);
    ed = !reset && bus.d_req && (m_locked || !bus.c_req || m_denied >= MAX_WAIT);
    ec = !reset && bus.c_req && !m_locked && !ed;
    ea = '0; ew = '0; ewe = 0; eoe = 0;
    if (ec) begin
      ea = bus.c_addr; ew = bus.c_wdata; ewe = bus.c_we; eoe = !bus.c_we;
    end else if (ed) begin
      ea = bus.d_addr; ew = bus.d_wdata; ewe = bus.d_we; eoe = !bus.d_we;
    end

    check("c_gnt",    32'(bus.c_gnt),             32'(ec));
    check("d_gnt",    32'(bus.d_gnt),             32'(ed));
    check("mem_we",   32'(bus.mem_write_enable),  32'(ewe));
    check("mem_oe",   32'(bus.mem_output_enable), 32'(eoe));
    check("mem_addr", 32'(bus.mem_addr),          32'(ea));
    check("mem_wdat", 32'(bus.mem_write_data),    32'(ew));
    check("c_rvalid", 32'(bus.c_rvalid),          32'(m_c_rv));
    check("d_rvalid", 32'(bus.d_rvalid),          32'(m_d_rv));
    check("c_rdata",  32'(bus.c_rdata),           32'(m_c_rdata));
    check("d_rdata",  32'(bus.d_rdata),           32'(m_d_rdata));

    w_en = bus.mem_write_enable;
    w_a  = bus.mem_addr;
    w_d  = bus.mem_write_data;

    @(posedge clk);
    #1;
    if (w_en) env_mem[w_a] = w_d;

    if (reset) begin
      m_locked  = 0;
      m_denied  = 0;
      m_c_rv    = 0;
      m_d_rv    = 0;
      m_c_rdata = '0;
      m_d_rdata = '0;
    end else begin
      c_rd   = ec && !bus.c_we;
      d_rd   = ed && !bus.d_we;
      m_c_rv = c_rd;
      m_d_rv = d_rd;
      if (c_rd) m_c_rdata = shadow[bus.c_addr];
      if (d_rd) m_d_rdata = shadow[bus.d_addr];
      if (ec && bus.c_we) shadow[bus.c_addr] = bus.c_wdata;
      if (ed && bus.d_we) shadow[bus.d_addr] = bus.d_wdata;
      if (m_locked) begin
        m_locked = bus.d_req && bus.d_lock;
      end else begin
        if (bus.d_req && !ed) m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
        else                  m_denied = 0;
        m_locked = ed && bus.d_lock;
      end
    end
    last_c = ec;
    last_d = ed;
  endtask

  // Pick new requests once the previous one was granted (or none pending);
  // otherwise the requester holds everything stable.
  task automatic next_inputs(input int c_pct, input int d_pct, input int lock_pct,
                             input int rst_pct, input bit c_always);
    reset = ($urandom_range(0, 99) < rst_pct);
    if (!bus.c_req || last_c) begin
      bus.c_req   = c_always || ($urandom_range(0, 99) < c_pct);
      bus.c_we    = $urandom_range(0, 1) == 1;
      bus.c_addr  = D_ADDR_W'($urandom_range(0, 31));
      bus.c_wdata = DATA_W'($urandom);
    end
    if (!bus.d_req || last_d) begin
      bus.d_req   = $urandom_range(0, 99) < d_pct;
      bus.d_we    = $urandom_range(0, 1) == 1;
      bus.d_lock  = $urandom_range(0, 99) < lock_pct;
      bus.d_addr  = D_ADDR_W'($urandom_range(0, 31));
      bus.d_wdata = DATA_W'($urandom);
    end
  endtask

  initial begin
    int waited;

    for (int i = 0; i < MEM_SZ; i++) begin
      logic [DATA_W-1:0] v;
      v = DATA_W'($urandom);
      env_mem[i] = v;
      shadow[i]  = v;
    end
    env_mem[12'h010] = 8'hA5;
    shadow[12'h010]  = 8'hA5;

    m_locked = 0; m_denied = 0; m_c_rv = 0; m_d_rv = 0;
    m_c_rdata = '0; m_d_rdata = '0; last_c = 0; last_d = 0;

    // Reset held two cycles with both requesters asking: nothing granted.
    reset       = 1'b1;
    bus.c_req   = 1'b1; bus.c_we = 1'b0; bus.c_addr = 12'h010; bus.c_wdata = '0;
    bus.d_req   = 1'b1; bus.d_we = 1'b0; bus.d_lock = 1'b0;
    bus.d_addr  = 12'h011; bus.d_wdata = '0;
    run_cycle();
    run_cycle();

    // Release: core read of 0x010 granted in the same cycle (C beats D).
    reset = 1'b0;
    run_cycle();
    check("rst_release_c_first", 32'(last_c), 32'd1);
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
    run_cycle();   // c_rvalid pulse checked by the model here
    check("core_read_a5", 32'(bus.c_rdata), 32'hA5);
    run_cycle();   // pulse has ended

    // Starvation: C requests every cycle, D write of 0x3C to 0x200.
    bus.c_req  = 1'b1;
    bus.d_req  = 1'b1; bus.d_we = 1'b1; bus.d_lock = 1'b0;
    bus.d_addr = 12'h200; bus.d_wdata = 8'h3C;
    waited = 0;
    run_cycle();
    while (!last_d && waited < 20) begin
      waited++;
      bus.c_addr = D_ADDR_W'($urandom_range(0, 31));
      bus.c_we   = $urandom_range(0, 1) == 1;
      bus.c_wdata = DATA_W'($urandom);
      run_cycle();
    end
    check("starve_denied_cycles", 32'(waited), 32'(MAX_WAIT));
    check("starve_mem_written",   32'(env_mem[12'h200]), 32'h3C);
    bus.d_req = 1'b0;
    bus.c_req = 1'b0;
    run_cycle();

    // Randomized phases: balanced traffic, core-saturated, lock-heavy with
    // occasional resets (including mid-lock and with reads in flight).
    for (int i = 0; i < 1200; i++) begin
      next_inputs(50, 50, 20, 0, 1'b0);
      run_cycle();
    end
    for (int i = 0; i < 400; i++) begin
      next_inputs(100, 60, 10, 0, 1'b1);
      run_cycle();
    end
    for (int i = 0; i < 800; i++) begin
      next_inputs(70, 70, 80, 3, 1'b0);
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always ends by itself.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_turtle_dmem_arbiter
